// File: rtl/alu_src_pipe_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | alu_src_pipe_mux : registered N-way operand selector, 1-entry buffer    |
// | Optional: ALU_SRC_SEL_ERR_EN (hold data + sticky sel_err on bad sel)    |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module alu_src_pipe_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    err_clr,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        xfer_cnt
);

  localparam logic [SEL_W:0] c_numIn = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] w_chan [NUM_IN];
  logic [WIDTH-1:0] w_selData;
  logic [WIDTH-1:0] w_nextData;
  logic             w_accept;
  logic             w_legal;

  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outSel;
  logic             r_outValid;
  logic [CNT_W-1:0] r_xferCnt;

  for (genvar gk = 0; gk < NUM_IN; gk++) begin : g_chan
    assign w_chan[gk] = in_bus[gk*WIDTH +: WIDTH];
  end

  // Out-of-range codes fall through to zero, never to an X or a latch.
  always_comb begin
    w_selData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) w_selData = w_chan[i];
    end
  end

  assign w_legal  = {1'b0, sel} < c_numIn;
  assign in_ready = !r_outValid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef ALU_SRC_SEL_ERR_EN
  logic r_selErr;

  assign w_nextData = w_legal ? w_selData : r_outData;

  // A new error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_selErr <= 1'b0;
    end else if (w_accept && !w_legal) begin
      r_selErr <= 1'b1;
    end else if (err_clr) begin
      r_selErr <= 1'b0;
    end
  end

  assign sel_err = r_selErr;
`else
  logic w_unused;

  assign w_nextData = w_selData;
  assign sel_err    = 1'b0;
  assign w_unused   = err_clr | w_legal;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outData  <= '0;
      r_outSel   <= '0;
      r_outValid <= 1'b0;
      r_xferCnt  <= '0;
    end else if (w_accept) begin
      r_outData  <= w_nextData;
      r_outSel   <= sel;
      r_outValid <= 1'b1;
      r_xferCnt  <= r_xferCnt + CNT_W'(1);
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_data  = r_outData;
  assign out_sel   = r_outSel;
  assign out_valid = r_outValid;
  assign xfer_cnt  = r_xferCnt;

endmodule
`default_nettype wire

// File: doc/alu_src_pipe_mux.md
# alu_src_pipe_mux

Parametrised, registered N-way operand selector with a single-entry valid/ready buffer, the successor to the fixed 3-way ALU source-A multiplexer in the multicycle datapath. Selects one of NUM_IN WIDTH-bit channels, registers the result and the select code, and holds it until the consumer (ALU input stage) accepts it. An out-of-range select code is decided behaviour: the previous output is held and a sticky error is raised, so the selector can never infer a latch or emit X.

## Interface

Parameters:
- WIDTH, 32, data width of each channel and of the output
- NUM_IN, 3, number of input channels (2..16)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN
- CNT_W, 16, width of the transfer counter

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- sel  in  SEL_W  channel select, sampled with the transfer
- in_bus  in  NUM_IN*WIDTH  packed channels; channel k at bits [k*WIDTH +: WIDTH]
- in_valid  in  1  producer offers sel/in_bus this cycle
- in_ready  out  1  block can accept this cycle
- out_data  out  WIDTH  registered selected data
- out_sel  out  SEL_W  select code of the held word
- out_valid  out  1  out_data/out_sel hold an unconsumed word
- out_ready  in  1  consumer accepts the held word this cycle
- err_clr  in  1  clears sel_err
- sel_err  out  1  sticky: an out-of-range sel was accepted
- xfer_cnt  out  CNT_W  number of accepted input transfers, wraps

## Operation

- Reset values: out_data = 0, out_sel = 0, out_valid = 0, sel_err = 0, xfer_cnt = 0. in_ready = 1 during and after reset.
- in_ready = !out_valid || out_ready (combinational from out_valid and out_ready; no path from in_valid).
- Accept: in_valid && in_ready. On accept: out_sel <= sel, out_valid <= 1, xfer_cnt <= xfer_cnt + 1 (mod 2**CNT_W).
- Data on accept: sel < NUM_IN gives out_data <= channel[sel]. sel >= NUM_IN: see Configuration.
- Drain: out_valid && out_ready && no accept gives out_valid <= 0. out_data and out_sel hold their last value.
- Simultaneous drain and accept: the new word replaces the old one and out_valid stays 1 (full throughput).
- No accept: out_data, out_sel and xfer_cnt hold. The held word never changes while out_valid && !out_ready.
- err_clr clears sel_err. If err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-transfer discards the held word. Any in_valid in the reset cycle is ignored, and xfer_cnt does not increment.

## Timing

- Latency: accepted input appears on out_data/out_valid at the next rising edge, so 1 cycle.
- Throughput: 1 word per cycle while out_ready = 1.
- Backpressure: with out_ready = 0 and out_valid = 1, in_ready = 0. The producer must hold sel/in_bus/in_valid stable.
- sel_err asserts in the cycle after the offending accept.

## Configuration

- ALU_SRC_SEL_ERR_EN defined: for an accept with sel >= NUM_IN, out_data keeps its previous value, out_sel records the illegal code, out_valid <= 1 and sel_err <= 1.
- Macro not defined: for the same accept, out_data <= 0 and out_sel records the code. sel_err is tied to 0 and err_clr is ignored.
- Legal-select behaviour is identical in both builds.

## Test plan

- Reset then idle: out_valid = 0, out_data = 0, in_ready = 1, xfer_cnt = 0.
- Defaults; in_bus ch0=0x11111111, ch1=0x22222222, ch2=0x33333333; sel=1, in_valid=1, out_ready=1 for one cycle -> next cycle out_data = 0x22222222, out_sel = 1, out_valid = 1, xfer_cnt = 1.
- Backpressure: hold out_ready = 0 after one word; offer sel=2 -> in_ready = 0, out_data stays 0x22222222. Raise out_ready -> same cycle in_ready = 1; 0x33333333 loads next edge with out_valid staying 1.
- Streaming: 5 back-to-back accepts (sel 0,1,2,0,1) with out_ready = 1 -> outputs in order on consecutive cycles, xfer_cnt = 5.
- Illegal sel=3 after out_data = 0x11111111. With ALU_SRC_SEL_ERR_EN: out_data stays 0x11111111, out_sel = 3, sel_err = 1. Pulse err_clr while a second sel=3 is accepted -> sel_err stays 1. Without the macro: out_data = 0, sel_err = 0.
- CNT_W=2: 4 accepts -> xfer_cnt wraps to 0. Assert reset while out_valid = 1 -> out_valid = 0 next cycle.
